// File: rtl/dmem_pkg.sv
// Shared encodings for the RV32I data-memory controller: access types, FSM states
// and the load lane-select/extension helper.
package dmem_pkg;

   localparam logic [1:0] ST_SW = 2'b00;
   localparam logic [1:0] ST_SH = 2'b01;
   localparam logic [1:0] ST_SB = 2'b10;

   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LB  = 3'b010;
   localparam logic [2:0] LD_LHU = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_WAIT   = 2'b01,
      S_ACCESS = 2'b10,
      S_RESP   = 2'b11
   } state_t;

   // Moves the addressed byte/halfword down to bit 0 and extends it.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  ltype,
                                               input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {off, 3'b000});
      h = off[1] ? word[31:16] : word[15:0];
      case (ltype)
         LD_LB:   load_extend = {{24{b[7]}}, b};
         LD_LBU:  load_extend = {24'd0, b};
         LD_LH:   load_extend = {{16{h[15]}}, h};
         LD_LHU:  load_extend = {16'd0, h};
         default: load_extend = word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_sram_be.sv
// Synchronous single-port word RAM with four byte enables. No reset: contents
// persist across controller reset.
module dmem_sram_be #(
   parameter int    DEPTH_WORDS = 1024,
   parameter string INIT_FILE   = ""
) (
   input  logic                           clock,
   input  logic                           i_we,
   input  logic [3:0]                     i_be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
   input  logic [31:0]                    i_wdata,
   output logic [31:0]                    o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clock) begin
      for (int i = 0; i < 4; i++) begin
         if (i_we && i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
      o_rdata <= r_mem[i_addr];
   end

endmodule

// File: rtl/dmem_ctrl_rv32i.sv
// RV32I data-memory controller: request/ack handshake, optional wait states,
// sized/extended loads, byte-lane stores and misalignment/range error reporting.
//
// state    | meaning
// S_IDLE   | ready; accepts cu_req and captures the request
// S_WAIT   | burning WAIT_CYCLES wait states
// S_ACCESS | RAM write, or load result + error registered
// S_RESP   | final cycle; ack pulses on the following cycle
module dmem_ctrl_rv32i
   import dmem_pkg::*;
#(
   parameter int    DEPTH_WORDS = 1024,
   parameter int    WAIT_CYCLES = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cu_req,
   input  logic        cu_store,
   input  logic [1:0]  cu_storetype,
   input  logic [2:0]  cu_loadtype,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] rs2,
   output logic [31:0] dmem_out,
   output logic        dmem_ack,
   output logic        dmem_err,
   output logic        dmem_busy
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t      r_state;
   logic [3:0]  r_wcnt;
   logic        r_store;
   logic [1:0]  r_stype;
   logic [2:0]  r_ltype;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_out;
   logic        r_ack;
   logic        r_err;

   logic          w_err;
   logic [3:0]    w_be;
   logic [31:0]   w_lane_data;
   logic          w_we;
   logic [AW-1:0] w_ram_addr;
   logic [31:0]   w_rdata;

   always_comb begin
      w_err = 1'b0;
      if (r_store) begin
         case (r_stype)
            ST_SW:   w_err = |r_addr[1:0];
            ST_SH:   w_err = r_addr[0];
            ST_SB:   w_err = 1'b0;
            default: w_err = 1'b1;
         endcase
      end else begin
         case (r_ltype)
            LD_LW:          w_err = |r_addr[1:0];
            LD_LH, LD_LHU:  w_err = r_addr[0];
            LD_LB, LD_LBU:  w_err = 1'b0;
            default:        w_err = 1'b1;
         endcase
      end
      if (r_addr[31:2] >= 30'(DEPTH_WORDS)) w_err = 1'b1;
   end

   always_comb begin
      w_be        = 4'b0000;
      w_lane_data = r_wdata;
      case (r_stype)
         ST_SW: w_be = 4'b1111;
         ST_SH: begin
            w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{r_wdata[15:0]}};
         end
         ST_SB: begin
            w_be        = 4'b0001 << r_addr[1:0];
            w_lane_data = {4{r_wdata[7:0]}};
         end
         default: w_be = 4'b0000;
      endcase
   end

   assign w_we = (r_state == S_ACCESS) && r_store && !w_err;

   // The RAM reads the incoming address on the accept edge so the word is
   // already on w_rdata by the ACCESS edge even with zero wait states.
   assign w_ram_addr = (r_state == S_IDLE) ? dmem_addr[AW+1:2] : r_addr[AW+1:2];

   dmem_sram_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INIT_FILE   (INIT_FILE)
   ) u_sram (
      .clock   (clock),
      .i_we    (w_we),
      .i_be    (w_be),
      .i_addr  (w_ram_addr),
      .i_wdata (w_lane_data),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_wcnt  <= 4'd0;
         r_store <= 1'b0;
         r_stype <= 2'b00;
         r_ltype <= 3'b000;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_out   <= 32'd0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cu_req) begin
                  r_store <= cu_store;
                  r_stype <= cu_storetype;
                  r_ltype <= cu_loadtype;
                  r_addr  <= dmem_addr;
                  r_wdata <= rs2;
                  if (WAIT_CYCLES > 0) begin
                     r_wcnt  <= 4'(WAIT_CYCLES - 1);
                     r_state <= S_WAIT;
                  end else begin
                     r_state <= S_ACCESS;
                  end
               end
            end
            S_WAIT: begin
               if (r_wcnt == 4'd0) r_state <= S_ACCESS;
               else                r_wcnt  <= r_wcnt - 4'd1;
            end
            S_ACCESS: begin
               r_err   <= w_err;
               r_out   <= (w_err || r_store) ? 32'd0
                                             : load_extend(w_rdata, r_ltype, r_addr[1:0]);
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_ack   <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dmem_out  = r_out;
   assign dmem_ack  = r_ack;
   assign dmem_err  = r_err;
   assign dmem_busy = (r_state != S_IDLE);

endmodule
